// File: rtl/sqrt_input_stage_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sqrt_input_stage_pkg: flag indices, exponent biases, FSM encodings
// Revision: 1.0
// ------------------------------------------------------------------
package sqrt_input_stage_pkg;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_NAN  = 2;

  localparam int SP_BIAS = 127;
  localparam int DP_BIAS = 1023;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  // Result flags for an operand that skips the core; NaN and invalid take precedence.
  function automatic logic [2:0] special_flags(input logic [2:0] flags, input logic sign);
    logic [2:0] f;
    f = 3'b000;
    if (flags[FLAG_NAN])
      f[FLAG_NAN] = 1'b1;
    else if (sign && !flags[FLAG_ZERO])
      f[FLAG_NAN] = 1'b1;
    else if (flags[FLAG_ZERO])
      f[FLAG_ZERO] = 1'b1;
    else if (flags[FLAG_INF])
      f[FLAG_INF] = 1'b1;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_in_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// sqrt_in_fifo: circular operand buffer with wrap-around pointers
// Revision: 1.0
// ------------------------------------------------------------------
module sqrt_in_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sqrt_input_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// sqrt_input_stage: operand FIFO, launch FSM and radicand prep for sqrt core
// Revision: 1.0
// ------------------------------------------------------------------
module sqrt_input_stage
  import sqrt_input_stage_pkg::*;
#(
  parameter int IN_M_SIZE  = 53,
  parameter int OUT_M_SIZE = 106,
  parameter int EXP_SIZE   = 11,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_type,
  input  logic                     in_sign,
  input  logic [EXP_SIZE-1:0]      in_exp,
  input  logic [IN_M_SIZE-1:0]     in_mantisa,
  input  logic [2:0]               in_flags,
  input  logic                     sqrt_ready,
  output logic                     start_sqrt,
  output logic                     bypass,
  output logic                     out_type,
  output logic                     out_sign,
  output logic [EXP_SIZE-1:0]      out_exp,
  output logic [OUT_M_SIZE-1:0]    out_mantisa,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int EW = 2 + EXP_SIZE + IN_M_SIZE + 3;

  logic [EW-1:0]         wr_data;
  logic [EW-1:0]         rd_data;
  logic                  full;
  logic                  empty;
  logic                  launch;
  logic [1:0]            state;
  logic [1:0]            state_next;

  logic                  hd_type;
  logic                  hd_sign;
  logic [EXP_SIZE-1:0]   hd_exp;
  logic [IN_M_SIZE-1:0]  hd_mant;
  logic [2:0]            hd_flags;
  logic                  hd_special;
  logic [2:0]            sp_flags;

  logic [EXP_SIZE:0]        bias_w;
  logic signed [EXP_SIZE:0] e_unb;
  logic signed [EXP_SIZE:0] e_half;
  logic [EXP_SIZE-1:0]      norm_exp;
  logic [OUT_M_SIZE-1:0]    m_wide;
  logic [OUT_M_SIZE-1:0]    norm_mant;

  assign wr_data  = {in_type, in_sign, in_exp, in_mantisa, in_flags};
  assign in_ready = ~full;

  sqrt_in_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (in_valid & in_ready),
    .pop     (launch),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign {hd_type, hd_sign, hd_exp, hd_mant, hd_flags} = rd_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; LAUNCH hides the cycle before the core drops sqrt_ready
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (launch) state_next = ST_LAUNCH;
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT:   if (sqrt_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (flush)
      state_next = ST_IDLE;
  end

  // Output logic
  always_comb begin
    launch = 1'b0;
    if (state == ST_IDLE && !empty && sqrt_ready && !flush)
      launch = 1'b1;
  end

  assign hd_special = (|hd_flags) | hd_sign;
  assign sp_flags   = special_flags(hd_flags, hd_sign);

  // Halve the unbiased exponent with floor; an odd exponent doubles the radicand instead
  assign bias_w    = hd_type ? (EXP_SIZE+1)'(DP_BIAS) : (EXP_SIZE+1)'(SP_BIAS);
  assign e_unb     = $signed({1'b0, hd_exp} - bias_w);
  assign e_half    = e_unb >>> 1;
  assign norm_exp  = EXP_SIZE'($unsigned(e_half) + bias_w);
  assign m_wide    = OUT_M_SIZE'(hd_mant) << (OUT_M_SIZE - IN_M_SIZE);
  assign norm_mant = e_unb[0] ? m_wide : (m_wide >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sqrt  <= 1'b0;
      bypass      <= 1'b0;
      out_type    <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_mantisa <= '0;
      out_flags   <= 3'b000;
    end else begin
      start_sqrt <= launch & ~hd_special;
      bypass     <= launch & hd_special;
      if (launch) begin
        out_type <= hd_type;
        if (hd_special) begin
          out_sign    <= sp_flags[FLAG_ZERO] & hd_sign;
          out_exp     <= '0;
          out_mantisa <= '0;
          out_flags   <= sp_flags;
        end else begin
          out_sign    <= 1'b0;
          out_exp     <= norm_exp;
          out_mantisa <= norm_mant;
          out_flags   <= 3'b000;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_input_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sqrt_input_stage: directed self-checking bench for sqrt_input_stage
// Revision: 1.0
// ------------------------------------------------------------------
module tb_sqrt_input_stage;

  localparam int IN_M  = 53;
  localparam int OUT_M = 106;
  localparam int EXPW  = 11;
  localparam int DEPTH = 2;

  localparam logic [IN_M-1:0] DP_ONE  = 53'h10_0000_0000_0000;
  localparam logic [IN_M-1:0] SP_NINE = 53'h12_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_type;
  logic             in_sign;
  logic [EXPW-1:0]  in_exp;
  logic [IN_M-1:0]  in_mantisa;
  logic [2:0]       in_flags;
  logic             sqrt_ready;
  logic             start_sqrt;
  logic             bypass;
  logic             out_type;
  logic             out_sign;
  logic [EXPW-1:0]  out_exp;
  logic [OUT_M-1:0] out_mantisa;
  logic [2:0]       out_flags;
  logic [1:0]       level;

  int errors = 0;
  int checks = 0;

  sqrt_input_stage #(
    .IN_M_SIZE  (IN_M),
    .OUT_M_SIZE (OUT_M),
    .EXP_SIZE   (EXPW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_type     (in_type),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mantisa  (in_mantisa),
    .in_flags    (in_flags),
    .sqrt_ready  (sqrt_ready),
    .start_sqrt  (start_sqrt),
    .bypass      (bypass),
    .out_type    (out_type),
    .out_sign    (out_sign),
    .out_exp     (out_exp),
    .out_mantisa (out_mantisa),
    .out_flags   (out_flags),
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic t, input logic s, input logic [EXPW-1:0] e,
                         input logic [IN_M-1:0] m, input logic [2:0] f);
    in_valid   = 1'b1;
    in_type    = t;
    in_sign    = s;
    in_exp     = e;
    in_mantisa = m;
    in_flags   = f;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_type = 1'b0; in_sign = 1'b0;
    in_exp = '0; in_mantisa = '0; in_flags = 3'b000; sqrt_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++; if ({start_sqrt, bypass} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {start_sqrt, bypass}); end
    checks++; if ({out_type, out_sign, out_flags} !== 5'b0) begin errors++; $display("FAIL reset_outs: got %b want 00000", {out_type, out_sign, out_flags}); end
    checks++; if (out_exp !== '0 || out_mantisa !== '0) begin errors++; $display("FAIL reset_data: exp %0d mant %h want 0", out_exp, out_mantisa); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_normal();
    logic            vt  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [EXPW-1:0] ve  [4] = '{11'd1025, 11'd1024, 11'd1022, 11'd130};
    logic [EXPW-1:0] vx  [4] = '{11'd1024, 11'd1023, 11'd1022, 11'd128};
    logic [IN_M-1:0] vm  [4];
    logic [OUT_M-1:0] want [4];
    vm[0] = DP_ONE; vm[1] = DP_ONE; vm[2] = DP_ONE; vm[3] = SP_NINE;
    want[0] = {1'b0, DP_ONE, 52'd0};
    want[1] = {DP_ONE, 53'd0};
    want[2] = {DP_ONE, 53'd0};
    want[3] = {SP_NINE, 53'd0};
    sqrt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_op(vt[i], 1'b0, ve[i], vm[i], 3'b000);
      checks++; if (start_sqrt !== 1'b0 || level !== 2'd1) begin errors++; $display("FAIL norm%0d_queued: start %b level %0d want 0/1", i, start_sqrt, level); end
      tick();
      checks++; if (start_sqrt !== 1'b1 || bypass !== 1'b0) begin errors++; $display("FAIL norm%0d_start: start %b bypass %b want 1/0", i, start_sqrt, bypass); end
      checks++; if (out_exp !== vx[i]) begin errors++; $display("FAIL norm%0d_exp: got %0d want %0d", i, out_exp, vx[i]); end
      checks++; if (out_mantisa !== want[i]) begin errors++; $display("FAIL norm%0d_mant: got %h want %h", i, out_mantisa, want[i]); end
      checks++; if ({out_type, out_sign, out_flags} !== {vt[i], 1'b0, 3'b000}) begin errors++; $display("FAIL norm%0d_tsf: got %b want %b", i, {out_type, out_sign, out_flags}, {vt[i], 4'b0}); end
      tick();
      checks++; if (start_sqrt !== 1'b0 || out_exp !== vx[i] || level !== 2'd0) begin errors++; $display("FAIL norm%0d_hold: start %b exp %0d level %0d", i, start_sqrt, out_exp, level); end
      repeat (2) tick();
    end
  endtask

  task automatic test_special();
    logic       ss [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0] sf [6] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b001, 3'b010};
    logic [2:0] xf [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b100};
    logic       xs [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    sqrt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_op(1'b1, ss[i], 11'd1025, DP_ONE, sf[i]);
      tick();
      checks++; if (bypass !== 1'b1 || start_sqrt !== 1'b0) begin errors++; $display("FAIL spec%0d_pulse: bypass %b start %b want 1/0", i, bypass, start_sqrt); end
      checks++; if (out_flags !== xf[i] || out_sign !== xs[i]) begin errors++; $display("FAIL spec%0d_flags: flags %b sign %b want %b/%b", i, out_flags, out_sign, xf[i], xs[i]); end
      checks++; if (out_exp !== '0 || out_mantisa !== '0) begin errors++; $display("FAIL spec%0d_zero: exp %0d mant %h want 0", i, out_exp, out_mantisa); end
      repeat (3) tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [EXPW-1:0] seen_exp [3];
    int              seen_cyc [3];
    logic [EXPW-1:0] want_exp [3] = '{11'd1024, 11'd1023, 11'd1022};
    int              n = 0;
    logic            acc;
    sqrt_ready = 1'b0;
    push_op(1'b1, 1'b0, 11'd1025, DP_ONE, 3'b000);
    checks++; if (level !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_one: level %0d ready %b want 1/1", level, in_ready); end
    push_op(1'b1, 1'b0, 11'd1024, DP_ONE, 3'b000);
    checks++; if (level !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: level %0d ready %b want 2/0", level, in_ready); end
    in_valid = 1'b1; in_exp = 11'd1022;
    tick();
    checks++; if (level !== 2'd2 || start_sqrt !== 1'b0) begin errors++; $display("FAIL b2b_stall: level %0d start %b want 2/0", level, start_sqrt); end
    sqrt_ready = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      acc = in_valid & in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      if (start_sqrt) begin
        seen_exp[n] = out_exp;
        seen_cyc[n] = c;
        n++;
      end
    end
    in_valid = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d launches want 3", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (seen_exp[i] !== want_exp[i]) begin errors++; $display("FAIL b2b_order%0d: exp %0d want %0d", i, seen_exp[i], want_exp[i]); end
    end
    for (int i = 1; i < n; i++) begin
      checks++; if (seen_cyc[i] - seen_cyc[i-1] < 3) begin errors++; $display("FAIL b2b_spacing%0d: got %0d want >=3", i, seen_cyc[i] - seen_cyc[i-1]); end
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_wait();
    int pulses = 0;
    sqrt_ready = 1'b1;
    push_op(1'b1, 1'b0, 11'd1025, DP_ONE, 3'b000);
    tick();
    sqrt_ready = 1'b0;
    push_op(1'b1, 1'b0, 11'd1024, DP_ONE, 3'b000);
    tick();
    checks++; if (level !== 2'd1 || out_exp !== 11'd1024) begin errors++; $display("FAIL wait_setup: level %0d exp %0d want 1/1024", level, out_exp); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_exp !== '0 || out_mantisa !== '0 || out_flags !== 3'b000) begin errors++; $display("FAIL arst_outs: exp %0d mant %h flags %b want 0", out_exp, out_mantisa, out_flags); end
    checks++; if (level !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_fifo: level %0d ready %b want 0/1", level, in_ready); end
    #1 rst = 1'b0;
    sqrt_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (start_sqrt || bypass) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL arst_drop: got %0d launches want 0", pulses); end
  endtask

  task automatic test_flush();
    int pulses = 0;
    sqrt_ready = 1'b0;
    push_op(1'b1, 1'b0, 11'd1025, DP_ONE, 3'b000);
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL flush_setup: level %0d want 1", level); end
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (level !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_level: level %0d ready %b want 0/1", level, in_ready); end
    sqrt_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (start_sqrt || bypass) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_nolaunch: got %0d launches want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_back_to_back();
    test_reset_mid_wait();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
